// File: rtl/cpu_pkg.sv
// cpu_pkg: shared call-stack constants and operation encoding.
// Revision 1.0 - initial release
`default_nettype none

package cpu_pkg;

    localparam int CS_ADDR_W = 12;
    localparam int CS_DEPTH  = 8;

    typedef enum logic [2:0] {
        CS_NOP     = 3'd0,
        CS_PUSH    = 3'd1,
        CS_POP     = 3'd2,
        CS_REPLACE = 3'd3,
        CS_FLUSH   = 3'd4
    } cs_op_t;

endpackage

`default_nettype wire

// File: rtl/cs_regfile.sv
// cs_regfile: return-address storage, one write port, one asynchronous read port, no reset.
// Revision 1.0 - initial release
`default_nettype none

module cs_regfile #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [ADDR_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [ADDR_W-1:0] rd_data
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/call_stack_unit.sv
// call_stack_unit: circular return-address stack with overflow/underflow flags.
// Revision 1.0 - initial release. Define CALL_STACK_STICKY_ERR_EN for sticky error flags.
`default_nettype none

module call_stack_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CS_ADDR_W,
    parameter int DEPTH  = CS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic                       flush,
    output logic [ADDR_W-1:0]          top_addr,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  wp_prev;
    logic [PTR_W:0]    cnt;
    cs_op_t            op;
    logic              is_empty;
    logic              is_full;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0] rd_data;
    logic              ovf_evt;
    logic              unf_evt;

    assign wp_prev  = wp - 1'b1;
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);

    // Push+pop on an empty stack degrades to a plain push.
    always_comb begin
        op = CS_NOP;
        if (flush) begin
            op = CS_FLUSH;
        end else if (push && pop && !is_empty) begin
            op = CS_REPLACE;
        end else if (push) begin
            op = CS_PUSH;
        end else if (pop) begin
            op = CS_POP;
        end
    end

    assign ovf_evt = (op == CS_PUSH) && is_full;
    assign unf_evt = (op == CS_POP) && is_empty;
    assign wr_en   = (op == CS_PUSH) || (op == CS_REPLACE);
    assign wr_ptr  = (op == CS_REPLACE) ? wp_prev : wp;

    cs_regfile #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_ptr  (wr_ptr),
        .wr_data (push_addr),
        .rd_ptr  (wp_prev),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            cnt <= '0;
        end else begin
            case (op)
                CS_FLUSH: begin
                    wp  <= '0;
                    cnt <= '0;
                end
                CS_PUSH: begin
                    // When full, wp already points at the oldest entry.
                    wp <= wp + 1'b1;
                    if (!is_full) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CS_POP: begin
                    if (!is_empty) begin
                        wp  <= wp_prev;
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (op == CS_FLUSH) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
`ifdef CALL_STACK_STICKY_ERR_EN
            overflow  <= overflow | ovf_evt;
            underflow <= underflow | unf_evt;
`else
            overflow  <= ovf_evt;
            underflow <= unf_evt;
`endif
        end
    end

    assign top_addr = is_empty ? '0 : rd_data;
    assign empty    = is_empty;
    assign full     = is_full;
    assign count    = cnt;

endmodule

`default_nettype wire

// File: tb/tb_call_stack_unit.sv
// tb_call_stack_unit: table-driven self-checking bench for call_stack_unit (DEPTH=8, ADDR_W=12).
// Revision 1.0 - initial release
`default_nettype none

module tb_call_stack_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        flush = 1'b0;
    logic [11:0] push_addr = '0;
    logic [11:0] top_addr;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    call_stack_unit #(.ADDR_W(12), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .flush     (flush),
        .top_addr  (top_addr),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    typedef struct {
        logic        push;
        logic        pop;
        logic        flush;
        logic [11:0] addr;
        int          cnt;
        logic [11:0] top;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic pu, input logic po, input logic fl, input logic [11:0] a,
                                input int c, input logic [11:0] t, input logic ov, input logic un);
        vec_t v;
        v.push = pu; v.pop = po; v.flush = fl; v.addr = a;
        v.cnt = c; v.top = t; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    task automatic step(input logic pu, input logic po, input logic fl, input logic [11:0] a);
        @(negedge clk);
        push = pu; pop = po; flush = fl; push_addr = a;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    logic sov = 1'b0;
    logic sun = 1'b0;

    initial begin
        // Basic push/pop/replace/underflow/flush
        vecs.push_back(mk(1, 0, 0, 12'h010, 1, 12'h010, 0, 0));
        vecs.push_back(mk(1, 0, 0, 12'h020, 2, 12'h020, 0, 0));
        vecs.push_back(mk(1, 0, 0, 12'h030, 3, 12'h030, 0, 0));
        vecs.push_back(mk(0, 1, 0, 12'h000, 2, 12'h020, 0, 0));
        vecs.push_back(mk(1, 1, 0, 12'h300, 2, 12'h300, 0, 0));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 12'h010, 0, 0));
        vecs.push_back(mk(0, 1, 0, 12'h000, 0, 12'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 12'h000, 0, 12'h000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 12'h000, 0, 12'h000, 0, 0));
        vecs.push_back(mk(1, 1, 0, 12'h0AA, 1, 12'h0AA, 0, 0));
        vecs.push_back(mk(1, 0, 0, 12'h0BB, 2, 12'h0BB, 0, 0));
        vecs.push_back(mk(1, 0, 0, 12'h0CC, 3, 12'h0CC, 0, 0));
        vecs.push_back(mk(1, 0, 1, 12'h0DD, 0, 12'h000, 0, 0));
        // Fill past full: 9th push overwrites the oldest and flags overflow
        for (int i = 1; i <= 9; i++) begin
            vecs.push_back(mk(1, 0, 0, 12'(i), (i > 8) ? 8 : i, 12'(i), (i == 9), 0));
        end
        vecs.push_back(mk(0, 0, 0, 12'h000, 8, 12'h009, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk(0, 1, 0, 12'h000, 8 - k, (k == 8) ? 12'h000 : 12'(9 - k), 0, 0));
        end
        vecs.push_back(mk(0, 1, 0, 12'h000, 0, 12'h000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 12'h000, 0, 12'h000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 12'h000, 0, 12'h000, 0, 0));
        // Stack 0x100, 0x200; replace with 0x300; pop exposes 0x100
        vecs.push_back(mk(1, 0, 0, 12'h100, 1, 12'h100, 0, 0));
        vecs.push_back(mk(1, 0, 0, 12'h200, 2, 12'h200, 0, 0));
        vecs.push_back(mk(1, 1, 0, 12'h300, 2, 12'h300, 0, 0));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 12'h100, 0, 0));
        vecs.push_back(mk(0, 0, 1, 12'h000, 0, 12'h000, 0, 0));

        // Reset state
        #12;
        check("reset_count", 32'(count), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_top", 32'(top_addr), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        check("reset_unf", 32'(underflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            step(v.push, v.pop, v.flush, v.addr);
`ifdef CALL_STACK_STICKY_ERR_EN
            sov = v.flush ? 1'b0 : (sov | v.ovf);
            sun = v.flush ? 1'b0 : (sun | v.unf);
`else
            sov = v.ovf;
            sun = v.unf;
`endif
            check($sformatf("v%0d_count", i), 32'(count), 32'(v.cnt));
            check($sformatf("v%0d_top", i), 32'(top_addr), 32'(v.top));
            check($sformatf("v%0d_empty", i), 32'(empty), 32'(v.cnt == 0));
            check($sformatf("v%0d_full", i), 32'(full), 32'(v.cnt == 8));
            check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(sov));
            check($sformatf("v%0d_unf", i), 32'(underflow), 32'(sun));
        end

        // Popped address is visible on top_addr during the pop cycle
        step(1, 0, 0, 12'h010);
        step(1, 0, 0, 12'h020);
        step(1, 0, 0, 12'h030);
        @(negedge clk);
        pop = 1'b1;
        #1;
        check("pop_cycle_top", 32'(top_addr), 32'h030);
        @(posedge clk);
        #1;
        pop = 1'b0;
        check("after_pop_top", 32'(top_addr), 32'h020);

        // Overflow raised, then asynchronous reset between clock edges
        for (int i = 0; i < 7; i++) step(1, 0, 0, 12'h111);
        check("prefill_full", 32'(full), 32'd1);
        step(1, 0, 0, 12'h222);
        check("ovf_before_rst", 32'(overflow), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_empty", 32'(empty), 32'd1);
        check("async_full", 32'(full), 32'd0);
        check("async_top", 32'(top_addr), 32'd0);
        check("async_ovf", 32'(overflow), 32'd0);

        // Push presented as reset releases is taken at the next edge
        @(negedge clk);
        push = 1'b1; push_addr = 12'h5A5; rst = 1'b1;
        @(posedge clk);
        #1;
        push = 1'b0;
        check("rel_push_count", 32'(count), 32'd1);
        check("rel_push_top", 32'(top_addr), 32'h5A5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/call_stack_unit.md
CALL_STACK_UNIT -- requirements
Module: call_stack_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, the width of a stored return address.
REQ-002 SHALL have parameter DEPTH, default 8, the number of entries; the value SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port push  in  1  push request from the CPU decode/branch stage.
REQ-006 SHALL have port pop  in  1  pop request from the CPU decode/branch stage.
REQ-007 SHALL have port push_addr  in  ADDR_W  return address to store.
REQ-008 SHALL have port flush  in  1  synchronous clear of the whole stack.
REQ-009 SHALL have port top_addr  out  ADDR_W  current top entry, combinational from state.
REQ-010 SHALL have port empty  out  1  high when count == 0.
REQ-011 SHALL have port full  out  1  high when count == DEPTH.
REQ-012 SHALL have port count  out  $clog2(DEPTH)+1  number of valid entries.
REQ-013 SHALL have port overflow  out  1  registered error flag for a push while full.
REQ-014 SHALL have port underflow  out  1  registered error flag for a pop while empty.

Function
REQ-015 The stack SHALL be a circular buffer with a write pointer wp, where top = entry[wp-1] mod DEPTH.
REQ-016 top_addr SHALL equal entry[wp-1] when count > 0, and 0 when empty.
REQ-017 Push only, count < DEPTH: store push_addr at wp, increment wp, increment count; the new value appears on top_addr the next cycle.
REQ-018 Push only, full: overwrite the oldest entry at wp, increment wp, keep count at DEPTH, and raise overflow.
REQ-019 Pop only, count > 0: decrement wp and decrement count; top_addr during the pop cycle is the popped address.
REQ-020 Pop only, empty: leave state unchanged and raise underflow.
REQ-021 Push and pop together, count > 0: overwrite entry[wp-1] with push_addr; wp and count stay unchanged.
REQ-022 Push and pop together, empty: behave as a push only; no underflow is raised.
REQ-023 flush SHALL take priority over push and pop: wp and count go to 0, the error flags clear, and entry contents are don't-care.
REQ-024 Pointer arithmetic SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-025 The error flags SHALL be set on the clock edge following the offending request.
REQ-026 Without CALL_STACK_STICKY_ERR_EN, the error flags SHALL be high for exactly one cycle per event.

Reset
REQ-027 On rst low, regardless of clock: wp = 0, count = 0, overflow = 0, underflow = 0, empty = 1, full = 0, top_addr = 0.
REQ-028 Entry storage SHALL NOT be reset.
REQ-029 A push or pop asserted in the cycle rst deasserts SHALL be honoured at the next rising edge.

Configuration
REQ-030 The macro CALL_STACK_STICKY_ERR_EN, when defined, SHALL make overflow and underflow sticky: once set, each stays high until flush or reset.
REQ-031 When CALL_STACK_STICKY_ERR_EN is undefined, the error flags SHALL be single-cycle pulses per REQ-026; all other behaviour SHALL be identical in both builds.

Structure
REQ-032 The constants CS_ADDR_W and CS_DEPTH, and the enum cs_op_t {CS_NOP, CS_PUSH, CS_POP, CS_REPLACE, CS_FLUSH}, SHALL live in the shared package cpu_pkg.
REQ-033 Storage SHALL be a sub-module cs_regfile: one write port and one asynchronous read port, no reset.
REQ-034 The pointer, count and error logic SHALL be implemented in call_stack_unit itself.

Verification
REQ-035 Reset, then push 0x010, 0x020, 0x030 -> count=3, top_addr=0x030; pop -> top_addr=0x030 that cycle, then 0x020.
REQ-036 Push 9 addresses 0x001..0x009 at DEPTH=8 -> full=1, count=8, overflow pulses once after the 9th push; 8 pops then return 0x009 down to 0x002.
REQ-037 Pop while empty -> underflow high the next cycle, count=0, top_addr=0; in the sticky build it stays high until flush.
REQ-038 Stack holds 0x100, 0x200; push 0x300 and pop together -> count=2, top_addr=0x300, then pop -> 0x100.
REQ-039 Stack holds 3 entries; flush with push in the same cycle -> count=0, empty=1, errors=0 next cycle.
REQ-040 Assert rst low mid-sequence between clock edges -> outputs reach their reset values immediately, without waiting for clk.
